// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the fetch stage.
//   PC_RESET    - first fetch address after reset
//   IM_WORDS    - instruction-memory depth in 32-bit words
//   RUN,
//   REDIR_PEND  - redirect FSM state encoding
//   NOP         - instruction word used for squashed/flushed/faulting fetches
// Helper:
//   seq_pc()    - sequential next fetch address (32-bit wrap)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;

  localparam logic [0:0]  RUN        = 1'b0;
  localparam logic [0:0]  REDIR_PEND = 1'b1;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_adel_chk.sv
// -----------------------------------------------------------------------------
// if_adel_chk
// Combinational fetch-address error check. Flags an address that is not
// word aligned or lies outside PC_RESET .. PC_RESET+4*IM_WORDS-1.
// Addresses are never folded modulo the memory depth.
// Parameters:
//   PC_RESET  - base of the legal instruction window
//   IM_WORDS  - window size in words
// Ports:
//   addr  in  [31:0]  fetch address
//   adel  out         1 = misaligned or out-of-range
// -----------------------------------------------------------------------------
module if_adel_chk #(
  parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
  parameter int          IM_WORDS = cpu_pkg::IM_WORDS
) (
  input  logic [31:0] addr,
  output logic        adel
);

  // Upper bound computed at 33 bits so a window touching the top of the
  // address space does not wrap back to a small value.
  localparam logic [32:0] LIMIT = {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);

  logic misaligned;
  logic below_base;
  logic above_top;

  assign misaligned = (addr[1:0] != 2'b00);
  assign below_base = (addr < PC_RESET);
  assign above_top  = ({1'b0, addr} >= LIMIT);
  assign adel       = misaligned | below_base | above_top;

endmodule

// File: rtl/if_unit.sv
// -----------------------------------------------------------------------------
// if_unit
// Instruction fetch stage: program counter, redirect FSM and the registered
// F/D stage register.
//
// Parameters:
//   PC_RESET  - first fetch address after reset
//   IM_WORDS  - instruction-memory depth in words (legal fetch window size)
// Ports:
//   clk          in        rising-edge clock
//   reset        in        synchronous, active-low
//   stall        in        hold PC and the F/D register
//   flush        in        invalidate the F/D register (wins over stall there)
//   redirect     in        branch/jump taken strobe
//   redirect_pc  in  [31:0] redirect target
//   PC           out [31:0] current fetch address to instruction memory
//   Instr        in  [31:0] combinational instruction word at PC
//   D_Instr      out [31:0] registered instruction
//   D_PC         out [31:0] registered fetch address
//   D_valid      out        registered valid
//   D_exc_adel   out        registered fetch address error
//
// Build option:
//   IF_UNIT_ADEL_CHECK_EN - when defined, misaligned or out-of-window fetches
//   are replaced by NOP and reported on D_exc_adel. When undefined,
//   D_exc_adel is tied low and every fetched word passes through unchanged.
// -----------------------------------------------------------------------------
module if_unit #(
  parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
  parameter int          IM_WORDS = cpu_pkg::IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic        D_valid,
  output logic        D_exc_adel
);

  import cpu_pkg::*;

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [31:0] pend_pc;
  logic [31:0] pend_pc_next;
  logic [31:0] pc_next;
  logic        adel;
  logic        fetch_err;

  // ---------------------------------------------------------------------------
  // Address check on the current fetch address
  // ---------------------------------------------------------------------------
  if_adel_chk #(
    .PC_RESET (PC_RESET),
    .IM_WORDS (IM_WORDS)
  ) u_adel_chk (
    .addr (PC),
    .adel (adel)
  );

`ifdef IF_UNIT_ADEL_CHECK_EN
  assign fetch_err = adel;
`else
  // Checker result is not used in this build; fetches pass through as-is.
  logic adel_unused;
  assign adel_unused = adel;
  assign fetch_err   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-PC selection and redirect FSM
  // A redirect seen while stalled is remembered in pend_pc so it is not lost;
  // later redirects during the same stall overwrite it. A live redirect on the
  // release cycle beats the remembered one, since it is the newer target.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    pend_pc_next = pend_pc;
    pc_next      = PC;

    if (stall) begin
      if (redirect) begin
        pend_pc_next = redirect_pc;
        state_next   = REDIR_PEND;
      end
    end else begin
      state_next = RUN;
      if (redirect) begin
        pc_next = redirect_pc;
      end else if (state == REDIR_PEND) begin
        pc_next = pend_pc;
      end else begin
        pc_next = seq_pc(PC);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      PC      <= PC_RESET;
      state   <= RUN;
      pend_pc <= PC_RESET;
    end else begin
      PC      <= pc_next;
      state   <= state_next;
      pend_pc <= pend_pc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // F/D stage register
  // Flush clears the slot even during a stall; D_PC still follows stall so it
  // keeps naming the address that was (or would have been) in the slot.
  // ---------------------------------------------------------------------------
  logic exc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      D_Instr <= NOP;
      D_PC    <= PC_RESET;
      D_valid <= 1'b0;
      exc_q   <= 1'b0;
    end else if (flush) begin
      D_Instr <= NOP;
      D_valid <= 1'b0;
      exc_q   <= 1'b0;
      if (!stall) begin
        D_PC <= PC;
      end
    end else if (!stall) begin
      D_Instr <= fetch_err ? NOP : Instr;
      D_PC    <= PC;
      D_valid <= 1'b1;
      exc_q   <= fetch_err;
    end
  end

`ifdef IF_UNIT_ADEL_CHECK_EN
  assign D_exc_adel = exc_q;
`else
  // exc_q only ever loads 0 here; the output is tied low regardless.
  logic exc_unused;
  assign exc_unused = exc_q;
  assign D_exc_adel = 1'b0;
`endif

endmodule

// File: doc/if_unit.md
IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'h0000_3000, the first fetch address after reset.
REQ-002 The block SHALL have parameter IM_WORDS, default 4096, the instruction-memory depth in words; legal fetch range is PC_RESET .. PC_RESET+4*IM_WORDS-1.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port stall, input, 1, which holds the PC and the F/D output register.
REQ-006 The block SHALL have port flush, input, 1, which invalidates the F/D output register.
REQ-007 The block SHALL have port redirect, input, 1, a branch/jump taken strobe.
REQ-008 The block SHALL have port redirect_pc, input, 32, the target address.
REQ-009 The block SHALL have port PC, output, 32, the current fetch address driven to instruction memory.
REQ-010 The block SHALL have port Instr, input, 32, the combinational instruction memory word at PC.
REQ-011 The block SHALL have ports D_Instr, output, 32; D_PC, output, 32; and D_valid, output, 1, forming the registered F/D stage.
REQ-012 The block SHALL have port D_exc_adel, output, 1, a registered fetch address error.

Function
REQ-013 Each non-stalled cycle, PC SHALL update to redirect_pc when a redirect is taken or pending, else to PC+4 with 32-bit wrap.
REQ-014 Each non-stalled cycle, the F/D register SHALL capture Instr, PC and valid=1, giving one-cycle latency from PC to D_Instr.
REQ-015 While stall=1, PC, D_Instr, D_PC, D_valid and D_exc_adel SHALL hold their values.
REQ-016 The FSM SHALL have states RUN and REDIR_PEND; redirect=1 with stall=1 in RUN SHALL latch redirect_pc and enter REDIR_PEND.
REQ-017 In REDIR_PEND, the first cycle with stall=0 SHALL load PC from the latched target and return to RUN.
REQ-018 A new redirect arriving in REDIR_PEND SHALL overwrite the latched target (last wins).
REQ-019 Redirect with stall=0 SHALL take effect at the next edge without entering REDIR_PEND.
REQ-020 flush=1 SHALL load D_valid=0 and D_Instr=0 even when stall=1, with flush taking priority over stall for the F/D register only; PC SHALL still obey stall.
REQ-021 A fetch at a PC that is misaligned (PC[1:0]!=0) or outside the legal range SHALL register D_Instr=0 (nop) with D_exc_adel=1 when enabled.
REQ-022 PC SHALL never wrap modulo memory depth; an out-of-range PC SHALL be reported, not aliased.

Reset
REQ-023 When reset=0 at a rising edge, the block SHALL load PC=PC_RESET, D_Instr=0, D_PC=PC_RESET, D_valid=0, D_exc_adel=0 and state RUN, and SHALL discard any pending redirect.
REQ-024 Reset SHALL override stall, flush and redirect in the same cycle.

Configuration
REQ-025 With macro IF_UNIT_ADEL_CHECK_EN defined, the block SHALL perform the REQ-021 checks and drive D_exc_adel.
REQ-026 Without IF_UNIT_ADEL_CHECK_EN, D_exc_adel SHALL be tied to 0 and out-of-range instructions SHALL pass through unchanged.

Structure
REQ-027 PC_RESET, IM_WORDS, the state encoding (RUN, REDIR_PEND) and the NOP constant SHALL live in a shared package cpu_pkg.
REQ-028 The address-error check SHALL be one combinational sub-module, if_adel_chk.

Verification
REQ-029 Release reset with stall=0 -> PC goes 0x3000, 0x3004, 0x3008; D_valid rises one cycle after reset release; D_PC lags PC by one cycle.
REQ-030 Apply stall=1 for 3 cycles at PC=0x3008 -> PC and D_* are frozen; after release, PC=0x300C.
REQ-031 Assert redirect with target 0x3100 and stall=1, hold 2 cycles, then drop stall -> PC=0x3100 at the next edge; a second redirect to 0x3200 during the stall yields 0x3200.
REQ-032 Assert flush and stall together -> D_valid=0, D_Instr=0, PC held.
REQ-033 With IF_UNIT_ADEL_CHECK_EN defined, redirect to 0x3002 and then to 0x7000 -> D_exc_adel=1 and D_Instr=0 for each; redirect to 0x6FFC -> D_exc_adel=0.
REQ-034 Assert reset=0 while in REDIR_PEND -> PC=0x3000 and state RUN; the pending target is never fetched.
